mux_nx1_stream: RTL and testbench
=================================

Name: mux_nx1_stream

Overview:
- Parametrised successor to the 2:1 mux: N channels, W bits each, with one registered output stage and valid/ready handshake on every channel.
- Two selection modes: direct select (an external `sel` picks the channel) and round-robin arbitration among valid channels.
- Sits between multiple producers and one consumer, for example when sharing a datapath bus or merging result streams into a single register-file write port.

Parameters:
- N, 4: number of input channels; N >= 2.
- W, 8: data width per channel.
- SELW, $clog2(N): localparam, width of channel index fields.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational, at most one bit set.
- mode  in  1  0 = direct select, 1 = round-robin.
- sel  in  SELW  channel index used when mode = 0.
- out_data  out  W  registered output data.
- out_chan  out  SELW  index of the channel that supplied out_data.
- out_valid  out  1  output register holds valid data.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer last_ptr = N-1, so the first round-robin search starts at channel 0.
  - in_ready = 0 while rst_n = 0.
- Output register has two states, EMPTY (out_valid = 0) and FULL (out_valid = 1).
- load_en = !out_valid || out_ready. The register can accept a new word when empty or when it is being drained in the same cycle.
- Grant (combinational):
  - mode 0: grant = sel, grant_vld = (sel < N) && in_valid[sel]. If sel >= N, there is never a grant.
  - mode 1: first i with in_valid[i] = 1, searching last_ptr+1, last_ptr+2, ... modulo N with wrap-around. grant_vld = |in_valid.
- in_ready[i] = load_en && grant_vld && (grant == i). The transfer on channel i is in_valid[i] && in_ready[i].
- Rising edge with load_en = 1:
  - If grant_vld: out_data <= channel grant, out_chan <= grant, out_valid <= 1, last_ptr <= grant (updated in both modes).
  - Otherwise: out_valid <= 0. out_data and out_chan hold their values.
- Rising edge with load_en = 0 (FULL and out_ready = 0): all outputs and last_ptr hold; in_ready = 0.
- Latency is 1 cycle from the input transfer to out_valid.
- Throughput is 1 word per cycle with continuous out_ready; drain and load happen in the same cycle with no bubble.
- mode or sel changes affect only the next grant, never data already in the register. Mode switches do not reset last_ptr.
- Once out_valid = 1, out_data is stable until the handshake completes.
- Reset asserted mid-transfer drops the held word with no further outputs. The first grant after release follows the reset pointer (round-robin starts at channel 0).

Decomposition:
- Shared header `mux_defs.vh`: mode encodings MODE_DIRECT = 1'b0 and MODE_RR = 1'b1, and default N and W.
- Sub-module `rr_arbiter`: combinational. Inputs are req[N] and last_ptr; outputs are grant index and grant_vld. It is reused by later shared-bus blocks.
- Top level holds the output register, last_ptr, load_en, in_ready generation, and the mode-0 path.

Test Plan (N = 4, W = 8; channel i data = 8'h10 + i unless stated):
- Reset: with out_valid = 1 and out_data = 8'h12, pulse rst_n low between clock edges -> out_valid = 0, out_data = 0, out_chan = 0 immediately; in_ready = 4'b0000 during reset.
- Direct select: mode = 0, sel = 2, in_valid = 4'b0100, in_data[2] = 8'hA5, out_ready = 1 -> in_ready = 4'b0100 in cycle 0; cycle 1: out_valid = 1, out_data = 8'hA5, out_chan = 2. Then in_valid = 0 -> cycle 2: out_valid = 0.
- Direct select, unselected channel idle: mode = 0, sel = 1, in_valid = 4'b1101 -> in_ready = 4'b0000 and out_valid stays 0. Then sel = 5 is not representable, so force sel = 3 -> channel 3 transfers, out_data = 8'h13.
- Round-robin fairness: mode = 1 after reset, in_valid = 4'b1111, out_ready = 1 -> out_data sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10 on consecutive cycles; out_chan sequence 0, 1, 2, 3, 0.
- Backpressure: round-robin, out_valid = 1 with 8'h11, out_ready = 0 for 3 cycles -> out_data = 8'h11 held and in_ready = 0 for all 3 cycles. Release out_ready -> the same edge loads 8'h12 (channel 2), no bubble.
- Sparse wrap: mode = 1, last grant = 0, in_valid = 4'b1001 -> grants 3 then 0 (out_data 8'h13, 8'h10). Switch to mode = 0, sel = 0 mid-stream -> the next word comes from channel 0 and the held word is unchanged.

Source files
------------

// File: rtl/mux_nx1_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream_pkg
// Description : Shared definitions for the N:1 streaming multiplexer family:
//               selection-mode encodings, default geometry, the output
//               register state type and the modulo-N pointer helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_nx1_stream_pkg;

    // Selection mode encodings
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Default geometry
    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic int rr_index(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage : mux_nx1_stream_pkg
`default_nettype wire

// File: rtl/mux_nx1_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream_rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one past last_ptr, wrapping modulo N, and
//               returns the first requester. Kept free of any state so it can
//               be reused by other shared-bus blocks that own their pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_stream_rr_arbiter
    import mux_nx1_stream_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last_ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    // Walk the search order from farthest to nearest so the nearest requester
    // after last_ptr is the final (winning) assignment.
    always_comb begin
        grant     = '0;
        grant_vld = |req;
        for (int off = N; off >= 1; off--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i == rr_index(int'(last_ptr), off, N))) begin
                    grant = SELW'(i);
                end
            end
        end
    end

endmodule : mux_nx1_stream_rr_arbiter
`default_nettype wire

// File: rtl/mux_nx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream
// Description : N-channel, W-bit streaming multiplexer with one registered
//               output stage and valid/ready handshakes. Channel selection is
//               either direct (sel) or round-robin among valid channels.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_stream
    import mux_nx1_stream_pkg::*;
#(
    parameter  int N    = DEFAULT_N,
    parameter  int W    = DEFAULT_W,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    out_state_t      state_q,    state_d;
    logic [W-1:0]    data_q,     data_d;
    logic [SELW-1:0] chan_q,     chan_d;
    logic [SELW-1:0] last_ptr_q, last_ptr_d;

    logic            load_en;
    logic            dir_vld;
    logic [SELW-1:0] rr_grant;
    logic            rr_vld;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic [W-1:0]    grant_data;

    // Round-robin candidate, computed every cycle regardless of mode
    mux_nx1_stream_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .last_ptr  (last_ptr_q),
        .grant     (rr_grant),
        .grant_vld (rr_vld)
    );

    // Direct-select validity; an out-of-range sel matches no channel
    always_comb begin
        dir_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                dir_vld = in_valid[i];
            end
        end
    end

    // Mode steering, the load condition and the one-hot ready vector
    always_comb begin
        load_en   = (state_q == ST_EMPTY) || out_ready;
        grant     = (mode == MODE_RR) ? rr_grant : sel;
        grant_vld = (mode == MODE_RR) ? rr_vld   : dir_vld;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            // Gated by rst_n so no producer sees a handshake while in reset
            in_ready[i] = rst_n && load_en && grant_vld && (grant == SELW'(i));
        end
    end

    // Data of the granted channel
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // Next state: load on a grant, go empty when draining with nothing granted
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        chan_d     = chan_q;
        last_ptr_d = last_ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                state_d    = ST_FULL;
                data_d     = grant_data;
                chan_d     = grant;
                last_ptr_d = grant;
            end else begin
                state_d    = ST_EMPTY;
            end
        end
    end

    // Output register and round-robin pointer; pointer resets to N-1 so the
    // first round-robin search begins at channel 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            chan_q     <= '0;
            last_ptr_q <= SELW'(N - 1);
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule : mux_nx1_stream
`default_nettype wire

// File: tb/tb_mux_nx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nx1_stream
// Description : Directed, table-driven bench for mux_nx1_stream (N=4, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_stream;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;
    localparam logic [31:0] DDEF = 32'h13121110;   // channel i = 8'h10 + i
    localparam logic [31:0] DA5  = 32'h13A51110;   // channel 2 = 8'hA5

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    mux_nx1_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, step, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int step, input logic ov, input logic [7:0] od, input logic [1:0] oc);
        chk({tag, "_out_valid"}, step, 32'(out_valid), 32'(ov));
        chk({tag, "_out_data"},  step, 32'(out_data),  32'(od));
        chk({tag, "_out_chan"},  step, 32'(out_chan),  32'(oc));
    endtask

    task automatic run_step(input int k);
        mode      = tbl[k].mode;
        sel       = tbl[k].sel;
        in_valid  = tbl[k].iv;
        out_ready = tbl[k].ordy;
        in_data   = tbl[k].data;
        #1;
        chk("in_ready", k, 32'(in_ready), 32'(tbl[k].exp_rdy));
        @(posedge clk);
        #1;
        check_outputs("tbl", k, tbl[k].exp_ov, tbl[k].exp_od, tbl[k].exp_oc);
    endtask

    initial begin
        // Starting point for the table: empty register, pointer at N-1
        // Round-robin fairness, all channels valid
        tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0100, 1'b1, 8'h12, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b1000, 1'b1, 8'h13, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0001, 1'b1, 8'h10, 2'd0};
        // Backpressure with 8'h11 held for three cycles, then no-bubble reload
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b0, DDEF, 4'b0000, 1'b1, 8'h11, 2'd1};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b0, DDEF, 4'b0000, 1'b1, 8'h11, 2'd1};
        tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, DDEF, 4'b0000, 1'b1, 8'h11, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0100, 1'b1, 8'h12, 2'd2};
        // Sparse wrap: last grant 0, channels 0 and 3 valid
        tbl[10] = '{1'b1, 2'd0, 4'b0001, 1'b1, DDEF, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, DDEF, 4'b1000, 1'b1, 8'h13, 2'd3};
        tbl[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, DDEF, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, DDEF, 4'b1000, 1'b1, 8'h13, 2'd3};
        // Mode switch while held: word unchanged, next word from channel 0
        tbl[14] = '{1'b0, 2'd0, 4'b1001, 1'b0, DDEF, 4'b0000, 1'b1, 8'h13, 2'd3};
        tbl[15] = '{1'b0, 2'd0, 4'b1001, 1'b1, DDEF, 4'b0001, 1'b1, 8'h10, 2'd0};
        // Back to round-robin: pointer kept (0), so channel 1 is next
        tbl[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, DDEF, 4'b0010, 1'b1, 8'h11, 2'd1};
        // Direct select of channel 2 carrying 8'hA5, then idle
        tbl[17] = '{1'b0, 2'd2, 4'b0100, 1'b1, DA5,  4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[18] = '{1'b0, 2'd2, 4'b0000, 1'b1, DA5,  4'b0000, 1'b0, 8'hA5, 2'd2};
        // Selected channel idle while others are valid
        tbl[19] = '{1'b0, 2'd1, 4'b1101, 1'b1, DDEF, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[20] = '{1'b0, 2'd3, 4'b1101, 1'b1, DDEF, 4'b1000, 1'b1, 8'h13, 2'd3};
        tbl[21] = '{1'b0, 2'd3, 4'b0000, 1'b1, DDEF, 4'b0000, 1'b0, 8'h13, 2'd3};
        // Empty register loads even with out_ready low, then holds
        tbl[22] = '{1'b1, 2'd0, 4'b0010, 1'b0, DDEF, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[23] = '{1'b1, 2'd0, 4'b0010, 1'b0, DDEF, 4'b0000, 1'b1, 8'h11, 2'd1};

        // Reset state, with a valid request pending on channel 2
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b0100;
        in_data   = DDEF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 1'b0, 8'h00, 2'd0);
        chk("reset_in_ready", 0, 32'(in_ready), 32'h0);

        // Release and load 8'h12 from channel 2
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 1, 32'(in_ready), 32'b0100);
        @(posedge clk);
        #1;
        check_outputs("load12", 1, 1'b1, 8'h12, 2'd2);

        // Asynchronous reset between edges clears the held word immediately
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 2, 1'b0, 8'h00, 2'd0);
        chk("async_rst_in_ready", 2, 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence from the freshly reset state
        for (int k = 0; k < NV; k++) begin
            run_step(k);
        end

        // Reset mid-stream: round-robin restarts at channel 0 afterwards
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = DDEF;
        @(posedge clk);
        #1;
        check_outputs("pre_rst2", 0, 1'b1, 8'h12, 2'd2);
        rst_n = 1'b0;
        #2;
        check_outputs("rst2", 0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst2", 0, 1'b1, 8'h10, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_nx1_stream
`default_nettype wire
